// File: rtl/mem_ctrl.sv
// mem_ctrl: latches one cpu access, strobes the BRAM once, waits out the read latency, returns a ready pulse.
// Optional MEM_CTRL_ALIGN_CHECK_EN: misaligned byte addresses (addr[1:0] != 0) are rejected as faults.
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_fault,
  output logic                  mem_enable,
  output logic                  mem_reset,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_ain,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] WORDS_LIMIT = ADDR_WIDTH'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    fault_q, fault_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0]   mem_ain_q, mem_ain_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    mem_reset_q, mem_reset_d;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    req_fault;

  assign word_idx = {2'b00, cpu_addr[ADDR_WIDTH-1:2]};

  always_comb begin
    req_fault = (word_idx >= WORDS_LIMIT);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    req_fault = req_fault || (cpu_addr[1:0] != 2'b00);
`endif
  end

`ifndef MEM_CTRL_ALIGN_CHECK_EN
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];
`endif

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    mem_rw_d    = mem_rw_q;
    mem_ain_d   = mem_ain_q;
    mem_din_d   = mem_din_q;
    rdata_d     = rdata_q;
    mem_reset_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          // BRAM-facing registers only move for accesses that will really strobe the memory.
          fault_d = req_fault;
          if (!req_fault) begin
            mem_rw_d  = cpu_rw;
            mem_ain_d = word_idx;
            mem_din_d = cpu_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fault_q || mem_rw_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          rdata_d = mem_dout;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      mem_rw_q    <= 1'b0;
      mem_ain_q   <= '0;
      mem_din_q   <= '0;
      rdata_q     <= '0;
      mem_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      mem_rw_q    <= mem_rw_d;
      mem_ain_q   <= mem_ain_d;
      mem_din_q   <= mem_din_d;
      rdata_q     <= rdata_d;
      mem_reset_q <= mem_reset_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = (state_q == RESP);
  assign cpu_fault  = (state_q == RESP) && fault_q;
  assign mem_enable = (state_q == ISSUE) && !fault_q;
  assign mem_reset  = mem_reset_q;
  assign mem_rw     = mem_rw_q;
  assign mem_ain    = mem_ain_q;
  assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (read latency 1 and 3) on behavioural BRAMs, checked against a word-array model.
module tb_mem_ctrl;
  logic clock, reset, init_mem;
  logic [1:0] req, rw, ready, fault, en, mrst, mrw;
  logic [1:0][31:0] addr, wdata, rdata, ain, din, dout;

  logic [31:0] bram    [2][1024];
  logic [31:0] pipe    [2][3];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] exp_rd  [2];
  logic [31:0] exp_ain [2];
  logic [31:0] exp_din [2];
  logic        exp_rw  [2];
  int en_cnt [2] = '{0, 0};
  int oob_cnt = 0;
  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .MEM_LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset), .cpu_req(req[0]), .cpu_rw(rw[0]), .cpu_addr(addr[0]),
    .cpu_wdata(wdata[0]), .cpu_rdata(rdata[0]), .cpu_ready(ready[0]), .cpu_fault(fault[0]),
    .mem_enable(en[0]), .mem_reset(mrst[0]), .mem_rw(mrw[0]), .mem_ain(ain[0]),
    .mem_din(din[0]), .mem_dout(dout[0]));

  mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .MEM_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset), .cpu_req(req[1]), .cpu_rw(rw[1]), .cpu_addr(addr[1]),
    .cpu_wdata(wdata[1]), .cpu_rdata(rdata[1]), .cpu_ready(ready[1]), .cpu_fault(fault[1]),
    .mem_enable(en[1]), .mem_reset(mrst[1]), .mem_rw(mrw[1]), .mem_ain(ain[1]),
    .mem_din(din[1]), .mem_dout(dout[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int g, input int k);
    return 32'hC0DE0000 ^ (k * 32'h9E37) ^ g;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // BRAM: registered read, extra stages stretch latency; idle output is random so a mistimed capture shows.
  always @(posedge clock) begin
    for (int g = 0; g < 2; g++) begin
      if (init_mem) begin
        for (int k = 0; k < 1024; k++) bram[g][k] <= init_word(g, k);
      end else if (en[g] && mrw[g]) begin
        bram[g][ain[g][9:0]] <= din[g];
      end
      if (en[g]) begin
        en_cnt[g] <= en_cnt[g] + 1;
        if (ain[g] >= 32'd1024) oob_cnt <= oob_cnt + 1;
      end
      pipe[g][0] <= (en[g] && !mrw[g]) ? bram[g][ain[g][9:0]] : $urandom;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end

  assign dout[0] = pipe[0][0];
  assign dout[1] = pipe[1][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    for (int g = 0; g < 2; g++) begin
      chk("rst_mem_reset", mrst[g], 1);
      chk("rst_ready", ready[g], 0);
      chk("rst_fault", fault[g], 0);
      chk("rst_enable", en[g], 0);
      chk("rst_mem_rw", mrw[g], 0);
      chk("rst_mem_ain", ain[g], 0);
      chk("rst_mem_din", din[g], 0);
      chk("rst_rdata", rdata[g], 0);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      exp_rd[g] = '0; exp_ain[g] = '0; exp_din[g] = '0; exp_rw[g] = 1'b0;
    end
  endtask

  // Issue one access on instance i and check timing, fault, data and BRAM-side effects.
  task automatic access(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] idx;
    bit f;
    int lat, cyc, en0;
    idx = {2'b00, a[31:2]};
    f = (idx >= 32'd1024);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) f = 1'b1;
`endif
    lat = (f || w) ? 2 : 2 + lat_of(i);
    en0 = en_cnt[i];
    req[i] = 1'b1; rw[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clock); #1;
    rw[i] = 1'($urandom_range(0, 1)); addr[i] = $urandom; wdata[i] = $urandom;
    cyc = 1;
    while (!ready[i] && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (!f) begin
      exp_ain[i] = idx; exp_rw[i] = w; exp_din[i] = d;
      if (w) ref_mem[i][idx[9:0]] = d;
      else   exp_rd[i] = ref_mem[i][idx[9:0]];
    end
    chk("ready_cycle", cyc, lat);
    chk("fault", fault[i], f);
    chk("rdata", rdata[i], exp_rd[i]);
    chk("enable_count", en_cnt[i] - en0, f ? 0 : 1);
    chk("mem_ain", ain[i], exp_ain[i]);
    chk("mem_rw", mrw[i], exp_rw[i]);
    chk("mem_din", din[i], exp_din[i]);
    req[i] = 1'b0;
    @(posedge clock); #1;
    chk("ready_drop", ready[i], 0);
  endtask

  initial begin
    logic [31:0] idx;
    logic [1:0]  lsb;
    int i, r;
    reset = 1'b0; init_mem = 1'b1;
    req = '0; rw = '0; addr = '0; wdata = '0;
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 1024; k++) ref_mem[g][k] = init_word(g, k);
    model_reset();

    // reset and release
    @(posedge clock); #1;
    init_mem = 1'b0;
    chk_reset_vals();
    @(posedge clock); #1;
    reset = 1'b1;
    chk("mem_reset_held", mrst[0], 1);
    @(posedge clock); #1;
    chk("mem_reset_drop0", mrst[0], 0);
    chk("mem_reset_drop1", mrst[1], 0);
    for (int c = 0; c < 4; c++) begin
      chk("idle_no_ready0", ready[0], 0);
      chk("idle_no_ready1", ready[1], 0);
      @(posedge clock); #1;
    end

    // write then read back, latency 1
    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("ain_word4", ain[0], 32'd4);
    access(0, 1'b0, 32'h10, 32'h0);
    chk("rd_deadbeef", rdata[0], 32'hDEADBEEF);

    // out-of-range read and write, plus last valid word
    access(0, 1'b0, 32'h1000, 32'h0);
    chk("fault_keeps_rdata", rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 32'hFFC, 32'h0);
    access(0, 1'b1, 32'h1000, 32'h55AA55AA);

    // latency 3
    access(1, 1'b1, 32'h20, 32'h12345678);
    access(1, 1'b0, 32'h20, 32'h0);
    chk("rd_lat3", rdata[1], 32'h12345678);

    // reset while the latency-3 read is waiting
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'h20;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; req[1] = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk("reset_no_ready", ready[1], 0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mem_reset_drop_again", mrst[1], 0);
    access(1, 1'b0, 32'h20, 32'h0);
    chk("rd_after_reset", rdata[1], 32'h12345678);

    // misaligned read
    access(0, 1'b0, 32'h12, 32'h0);

    // random mix of reads, writes, boundary and misaligned addresses
    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 7)      idx = 32'($urandom_range(0, 15));
      else if (r < 9) idx = 32'($urandom_range(1020, 1027));
      else            idx = $urandom;
      lsb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      access(i, 1'($urandom_range(0, 1)), {idx[29:0], lsb}, $urandom);
    end

    chk("no_oob_enable", oob_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
